// File: rtl/spi_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_scheduler
// Description : Round-robin scheduler that shares one SPI transmit channel
//               between N_REQ word producers. It grants one word per frame,
//               pulses spi_start, then follows SS low/high to sequence the
//               next grant. A per-wait-state timeout recovers from a missing
//               or stuck SS response.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ack,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_data,
    input  logic                      spi_ss,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      xfer_done,
    output logic                      timeout_err
);

    localparam int                 c_IDX_W     = $clog2(N_REQ);
    localparam int                 c_CNT_W     = $clog2(TIMEOUT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_IDX_W-1:0] c_PTR_RESET = c_IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOW  = 2'd1,
        S_WAIT_HIGH = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   w_ptr_nxt;

    logic                 w_found;
    logic [c_IDX_W-1:0]   w_winner;
    logic [c_IDX_W-1:0]   w_cand;

    logic [N_REQ-1:0]     w_ack_nxt;
    logic                 w_start_nxt;
    logic [DATA_W-1:0]    w_data_nxt;
    logic [c_IDX_W-1:0]   w_gid_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;
    logic                 w_tmo_nxt;

    // Round-robin pick: scan farthest-to-nearest from ptr+1 so the nearest
    // requesting index is the last one written and therefore wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = c_IDX_W'((int'(r_ptr) + k) % N_REQ);
            if (req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_ack_nxt   = '0;
        w_start_nxt = 1'b0;
        w_data_nxt  = spi_data;
        w_gid_nxt   = grant_id;
        w_done_nxt  = 1'b0;
        w_tmo_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ack_nxt[w_winner] = 1'b1;
                    w_start_nxt         = 1'b1;
                    w_data_nxt          = req_data[w_winner*DATA_W +: DATA_W];
                    w_gid_nxt           = w_winner;
                    w_ptr_nxt           = w_winner;
                    w_cnt_nxt           = '0;
                    w_state_nxt         = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                // SS already low on the first cycle counts as frame start.
                if (!spi_ss) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT_HIGH;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_tmo_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (spi_ss) begin
                    w_done_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == c_CNT_LAST) begin
                    w_tmo_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State, pointer, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ptr       <= c_PTR_RESET;
            req_ack     <= '0;
            spi_start   <= 1'b0;
            spi_data    <= '0;
            grant_id    <= '0;
            busy        <= 1'b0;
            xfer_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ptr       <= w_ptr_nxt;
            req_ack     <= w_ack_nxt;
            spi_start   <= w_start_nxt;
            spi_data    <= w_data_nxt;
            grant_id    <= w_gid_nxt;
            busy        <= w_busy_nxt;
            xfer_done   <= w_done_nxt;
            timeout_err <= w_tmo_nxt;
        end
    end

endmodule
`default_nettype wire
